// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access size codes and FSM states.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
interface load_store_unit_if #(
   parameter int unsigned ADDR_W = 32
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              stall;
   logic              misalign;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, stall, misalign, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, stall, misalign, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts/extends load data and merges sub-word store data.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[8*addr_lo_i +: 8];
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      load_o   = rdata_i;
      merge_o  = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            merge_o[8*addr_lo_i +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
            else              merge_o[15:0]  = wdata_i[15:0];
         end
         default: begin
            load_o  = rdata_i;
            merge_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit; sub-word stores use a two-cycle read-modify-write.
// Optional MISALIGN_TRAP_EN suppresses and flags misaligned half/word accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   load_store_unit_if.slave   bus
);

   lsu_state_e        state_q, state_d;
   logic [31:0]       merge_q, merge_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              misalign_q, misalign_d;

   logic              ready;
   logic              accept;
   logic              is_word;
   logic              fault;
   logic [31:0]       load_data;
   logic [31:0]       merge_data;

   assign is_word = bus.req_size[1];

`ifdef MISALIGN_TRAP_EN
   assign fault = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                  (is_word && (bus.req_addr[1:0] != 2'b00));
`else
   assign fault = 1'b0;
`endif

   lsu_lane u_lane (
      .size_i     (bus.req_size),
      .unsigned_i (bus.req_unsigned),
      .addr_lo_i  (bus.req_addr[1:0]),
      .rdata_i    (bus.mem_rdata),
      .wdata_i    (bus.req_wdata),
      .load_o     (load_data),
      .merge_o    (merge_data)
   );

   always_comb begin
      ready         = (state_q == ST_IDLE);
      accept        = bus.req_valid && ready;
      bus.req_ready = ready;
      bus.stall     = !ready;
      if (state_q == ST_WRITE) begin
         bus.mem_addr  = addr_q;
         bus.mem_wdata = merge_q;
         bus.mem_we    = 1'b1;
      end else begin
         bus.mem_addr  = {bus.req_addr[ADDR_W-1:2], 2'b00};
         bus.mem_wdata = bus.req_wdata;
         bus.mem_we    = accept && bus.req_write && is_word && !fault;
      end
   end

   always_comb begin
      state_d      = ST_IDLE;
      merge_d      = merge_q;
      addr_d       = addr_q;
      resp_valid_d = accept && !bus.req_write;
      resp_rdata_d = resp_rdata_q;
      misalign_d   = accept && fault;
      if (accept && !bus.req_write) begin
         resp_rdata_d = fault ? 32'h0 : load_data;
      end
      // Sub-word store: capture merged word now, write it in the next cycle.
      if (accept && bus.req_write && !is_word && !fault) begin
         state_d = ST_WRITE;
         merge_d = merge_data;
         addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         merge_q      <= 32'h0;
         addr_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         merge_q      <= merge_d;
         addr_q       <= addr_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         misalign_q   <= misalign_d;
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-only behavioural data memory.
module tb_load_store_unit;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   logic [31:0] mem [0:255];

   load_store_unit_if #(.ADDR_W(32)) bus ();

   load_store_unit #(.ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      bus.req_valid    = 1'b1;
      bus.req_write    = wr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One load, accepted on the next edge; checks the single-cycle response pulse.
   task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp);
      drive(1'b0, sz, uns, addr, 32'h0);
      #1;
      check({tag, "_we"}, {31'h0, bus.mem_we}, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      check({tag, "_vld"}, {31'h0, bus.resp_valid}, 32'h1);
      check({tag, "_data"}, bus.resp_rdata, exp);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h40] = 32'h8899AABB;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      reset = 1'b1;
      repeat (3) tick();
      check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
      check("rst_stall", {31'h0, bus.stall}, 32'h0);
      check("rst_we", {31'h0, bus.mem_we}, 32'h0);
      check("rst_vld", {31'h0, bus.resp_valid}, 32'h0);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_mis", {31'h0, bus.misalign}, 32'h0);
      reset = 1'b0;
      tick();

      // Loads from 0x100 = 0x8899AABB
      load_chk("lb_s", 2'b00, 1'b0, 32'h101, 32'hFFFFFFAA);
      tick();
      check("lb_pulse", {31'h0, bus.resp_valid}, 32'h0);
      check("lb_hold", bus.resp_rdata, 32'hFFFFFFAA);
      load_chk("lb_u", 2'b00, 1'b1, 32'h101, 32'h000000AA);
      load_chk("lh_s", 2'b01, 1'b0, 32'h102, 32'hFFFF8899);
      load_chk("lh_u", 2'b01, 1'b1, 32'h102, 32'h00008899);
      load_chk("lb0_u", 2'b00, 1'b1, 32'h100, 32'h000000BB);
      load_chk("lw11", 2'b11, 1'b0, 32'h100, 32'h8899AABB);

      // Byte store with a load held upstream during WRITE
      drive(1'b1, 2'b00, 1'b0, 32'h102, 32'h0000005C);
      #1;
      check("sb_acc_we", {31'h0, bus.mem_we}, 32'h0);
      check("sb_acc_stall", {31'h0, bus.stall}, 32'h0);
      tick();
      drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      #1;
      check("sb_wr_stall", {31'h0, bus.stall}, 32'h1);
      check("sb_wr_ready", {31'h0, bus.req_ready}, 32'h0);
      check("sb_wr_we", {31'h0, bus.mem_we}, 32'h1);
      check("sb_wr_addr", bus.mem_addr, 32'h100);
      check("sb_wr_data", bus.mem_wdata, 32'h885CAABB);
      tick();
      check("sb_end_stall", {31'h0, bus.stall}, 32'h0);
      check("sb_end_we", {31'h0, bus.mem_we}, 32'h0);
      check("sb_held_vld", {31'h0, bus.resp_valid}, 32'h0);
      check("sb_mem", mem[8'h40], 32'h885CAABB);
      tick();
      bus.req_valid = 1'b0;
      check("sb_lw_vld", {31'h0, bus.resp_valid}, 32'h1);
      check("sb_lw_data", bus.resp_rdata, 32'h885CAABB);

      // Word store
      drive(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);
      #1;
      check("sw_we", {31'h0, bus.mem_we}, 32'h1);
      check("sw_stall", {31'h0, bus.stall}, 32'h0);
      check("sw_addr", bus.mem_addr, 32'h200);
      tick();
      bus.req_valid = 1'b0;
      check("sw_stall2", {31'h0, bus.stall}, 32'h0);
      check("sw_vld", {31'h0, bus.resp_valid}, 32'h0);
      load_chk("sw_lw", 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);

      // Halfword store into the upper lane
      drive(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234CAFE);
      tick();
      bus.req_valid = 1'b0;
      check("sh_wr_data", bus.mem_wdata, 32'hCAFEBEEF);
      tick();
      load_chk("sh_lh_u", 2'b01, 1'b1, 32'h202, 32'h0000CAFE);
      load_chk("sh_lb_s", 2'b00, 1'b0, 32'h203, 32'hFFFFFFCA);

      // Reset in the middle of a byte-store RMW drops the write
      drive(1'b1, 2'b10, 1'b0, 32'h100, 32'h8899AABB);
      tick();
      drive(1'b1, 2'b00, 1'b0, 32'h100, 32'h00000011);
      tick();
      bus.req_valid = 1'b0;
      check("rw_stall", {31'h0, bus.stall}, 32'h1);
      reset = 1'b1;
      #1;
      check("rw_we", {31'h0, bus.mem_we}, 32'h0);
      check("rw_stall0", {31'h0, bus.stall}, 32'h0);
      check("rw_rdata", bus.resp_rdata, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      check("rw_mem", mem[8'h40], 32'h8899AABB);
      check("rw_ready", {31'h0, bus.req_ready}, 32'h1);
      tick();

      // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
      load_chk("ma_lh", 2'b01, 1'b0, 32'h103, 32'h0);
      check("ma_lh_mis", {31'h0, bus.misalign}, 32'h1);
      drive(1'b1, 2'b10, 1'b0, 32'h301, 32'h12345678);
      #1;
      check("ma_sw_we", {31'h0, bus.mem_we}, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      check("ma_sw_mis", {31'h0, bus.misalign}, 32'h1);
      check("ma_sw_stall", {31'h0, bus.stall}, 32'h0);
      tick();
      check("ma_mis_pulse", {31'h0, bus.misalign}, 32'h0);
      check("ma_sw_mem", mem[8'hC0], 32'h0);
`else
      load_chk("ma_lh", 2'b01, 1'b0, 32'h103, 32'hFFFF8899);
      check("ma_lh_mis", {31'h0, bus.misalign}, 32'h0);
      drive(1'b1, 2'b10, 1'b0, 32'h301, 32'h12345678);
      #1;
      check("ma_sw_we", {31'h0, bus.mem_we}, 32'h1);
      check("ma_sw_addr", bus.mem_addr, 32'h300);
      tick();
      bus.req_valid = 1'b0;
      check("ma_sw_mis", {31'h0, bus.misalign}, 32'h0);
      tick();
      check("ma_sw_mem", mem[8'hC0], 32'h12345678);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
